// File: rtl/adc_align_ctrl_if.sv
// rtl/adc_align_ctrl_if.sv - control/status bundle between a segment deserializer and adc_align_ctrl
interface adc_align_ctrl_if;
  logic        i_start;
  logic [95:0] i_dout;
  logic        o_dsr_rst;
  logic        o_bit_slip_evn;
  logic        o_bit_slip_odd;
  logic        o_aligned;
  logic        o_fail;
  logic        o_strt_pipe;
  logic [3:0]  o_slip_cnt;
  logic [1:0]  o_retry_cnt;
  logic [2:0]  o_state;

  modport master (
    output i_start, i_dout,
    input  o_dsr_rst, o_bit_slip_evn, o_bit_slip_odd, o_aligned, o_fail,
    input  o_strt_pipe, o_slip_cnt, o_retry_cnt, o_state
  );

  modport slave (
    input  i_start, i_dout,
    output o_dsr_rst, o_bit_slip_evn, o_bit_slip_odd, o_aligned, o_fail,
    output o_strt_pipe, o_slip_cnt, o_retry_cnt, o_state
  );
endinterface

// File: rtl/adc_align_ctrl.sv
// rtl/adc_align_ctrl.sv - per-segment ADC deserializer alignment FSM (ALIGN_MONITOR_EN adds lock monitor)
module adc_align_ctrl #(
  parameter logic [11:0] PATTERN   = 12'h463,
  parameter logic [7:0]  CH_MASK   = 8'hFF,
  parameter int          RST_CYC   = 4,
  parameter int          SETTLE    = 16,
  parameter int          SLIP_WAIT = 4,
  parameter int          LOCK_CNT  = 8,
  parameter int          MAX_RETRY = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_b,
  adc_align_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_SLIP   = 3'd4,
    S_WAIT   = 3'd5,
    S_LOCKED = 3'd6,
    S_FAILED = 3'd7
  } state_t;

  // Terminal values of the shared cycle counter and the match/retry counters.
  localparam logic [7:0] RST_LAST    = 8'(RST_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] WAIT_LAST   = 8'(SLIP_WAIT - 1);
  localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);
  localparam logic [1:0] RETRY_LAST  = 2'(MAX_RETRY - 1);
  localparam logic [3:0] SLIP_LAST   = 4'd11;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_match, w_match_nxt;
  logic [3:0] r_slip, w_slip_nxt;
  logic [1:0] r_retry, w_retry_nxt;
  logic [1:0] w_retry_inc;
  logic       w_match;

  logic       r_dsr_rst;
  logic       r_slip_evn;
  logic       r_slip_odd;
  logic       r_aligned;
  logic       r_fail;
  logic       r_strt_pipe;

`ifdef ALIGN_MONITOR_EN
  logic [1:0] r_mon, w_mon_nxt;
`endif

  // Full match: every enabled channel carries the training word; an empty mask never matches.
  always_comb begin
    w_match = |CH_MASK;
    for (int n = 0; n < 8; n++) begin
      if (CH_MASK[n] && (bus.i_dout[n*12 +: 12] != PATTERN)) begin
        w_match = 1'b0;
      end
    end
  end

  assign w_retry_inc = (r_retry == 2'd3) ? r_retry : r_retry + 2'd1;

  // Next-state and counter update; START overrides everything except reset.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = 8'd0;
    w_match_nxt = r_match;
    w_slip_nxt  = r_slip;
    w_retry_nxt = r_retry;
`ifdef ALIGN_MONITOR_EN
    w_mon_nxt   = 2'd0;
`endif

    case (r_state)
      S_IDLE: begin
      end
      S_RESET: begin
        if (r_cnt == RST_LAST) w_state_nxt = S_SETTLE;
        else                   w_cnt_nxt   = r_cnt + 8'd1;
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = S_CHECK;
          w_match_nxt = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_CHECK: begin
        if (w_match) begin
          if (r_match == LOCK_LAST) w_state_nxt = S_LOCKED;
          else                      w_match_nxt = r_match + 4'd1;
        end else begin
          w_match_nxt = 4'd0;
          if (r_slip < SLIP_LAST) begin
            w_state_nxt = S_SLIP;
          end else begin
            // Whole word rotation tried without success.
            w_retry_nxt = w_retry_inc;
            if (r_retry < RETRY_LAST) begin
              w_slip_nxt  = 4'd0;
              w_state_nxt = S_RESET;
            end else begin
              w_state_nxt = S_FAILED;
            end
          end
        end
      end
      S_SLIP: begin
        w_slip_nxt  = r_slip + 4'd1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == WAIT_LAST) begin
          w_state_nxt = S_CHECK;
          w_match_nxt = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_LOCKED: begin
`ifdef ALIGN_MONITOR_EN
        // Four consecutive misses while locked means the lanes drifted: relock from scratch.
        if (w_match) begin
          w_mon_nxt = 2'd0;
        end else if (r_mon == 2'd3) begin
          w_state_nxt = S_RESET;
          w_slip_nxt  = 4'd0;
          w_retry_nxt = 2'd0;
        end else begin
          w_mon_nxt = r_mon + 2'd1;
        end
`endif
      end
      S_FAILED: begin
      end
    endcase

    if (bus.i_start) begin
      w_state_nxt = S_RESET;
      w_cnt_nxt   = 8'd0;
      w_match_nxt = 4'd0;
      w_slip_nxt  = 4'd0;
      w_retry_nxt = 2'd0;
`ifdef ALIGN_MONITOR_EN
      w_mon_nxt   = 2'd0;
`endif
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_match <= 4'd0;
      r_slip  <= 4'd0;
      r_retry <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_match <= w_match_nxt;
      r_slip  <= w_slip_nxt;
      r_retry <= w_retry_nxt;
    end
  end

`ifdef ALIGN_MONITOR_EN
  // Consecutive-miss counter for the locked-state monitor.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) r_mon <= 2'd0;
    else          r_mon <= w_mon_nxt;
  end
`endif

  // Registered outputs decoded from the upcoming state so they line up with r_state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_dsr_rst   <= 1'b0;
      r_slip_evn  <= 1'b0;
      r_slip_odd  <= 1'b0;
      r_aligned   <= 1'b0;
      r_fail      <= 1'b0;
      r_strt_pipe <= 1'b0;
    end else begin
      r_dsr_rst   <= (w_state_nxt == S_RESET);
      r_slip_evn  <= (w_state_nxt == S_SLIP) && !w_slip_nxt[0];
      r_slip_odd  <= (w_state_nxt == S_SLIP) &&  w_slip_nxt[0];
      r_aligned   <= (w_state_nxt == S_LOCKED);
      r_fail      <= (w_state_nxt == S_FAILED);
      r_strt_pipe <= (w_state_nxt == S_LOCKED) && (r_state != S_LOCKED);
    end
  end

  assign bus.o_dsr_rst      = r_dsr_rst;
  assign bus.o_bit_slip_evn = r_slip_evn;
  assign bus.o_bit_slip_odd = r_slip_odd;
  assign bus.o_aligned      = r_aligned;
  assign bus.o_fail         = r_fail;
  assign bus.o_strt_pipe    = r_strt_pipe;
  assign bus.o_slip_cnt     = r_slip;
  assign bus.o_retry_cnt    = r_retry;
  assign bus.o_state        = r_state;

endmodule
